// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter.
//   state_t / IDLE, ACCESS, RESP : FSM state encoding
//   owner_t / OWN_IF, OWN_D      : which requester owns the current transaction
//   SIZE_BYTE/HALF/WORD          : memory access-size encodings
//   req_misaligned()             : flags illegal-size or misaligned data requests
package mem_arb_pkg;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP   = 2'd2;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // True when a data request must be answered with an error instead of a memory access.
  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = addr_lo[0];
      SIZE_WORD: err = (addr_lo != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
//   slave  : view of the arbiter itself
//   master : view of the environment (requesters plus memory model)
interface mem_port_arbiter_if;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;

  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_out;

  modport slave (
    input  if_req_valid, if_addr,
    input  d_req_valid, d_addr, d_wdata, d_we, d_size,
    input  mem_data_out,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_address, mem_data_in, mem_read_write, mem_access_size
  );

  modport master (
    output if_req_valid, if_addr,
    output d_req_valid, d_addr, d_wdata, d_we, d_size,
    output mem_data_out,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_address, mem_data_in, mem_read_write, mem_access_size
  );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Grant logic with a data-streak limiter.
//   clock, reset      : clock and async active-low reset
//   enable            : arbiter may accept a request this cycle
//   if_req_valid      : fetch request pending
//   d_req_valid       : data request pending
//   grant_if, grant_d : one-hot (or zero) grant for this cycle
module mem_arb_prio #(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic if_req_valid,
  input  logic d_req_valid,
  output logic grant_if,
  output logic grant_d
);

  localparam int unsigned CntW = $clog2(MAX_DATA_STREAK + 1);

  logic [CntW-1:0] streak_q;
  logic            streak_max;

  assign streak_max = (streak_q == CntW'(MAX_DATA_STREAK));

  // Data wins unless it has already won MAX_DATA_STREAK times in a row over a waiting fetch.
  assign grant_if = enable & if_req_valid & (~d_req_valid | streak_max);
  assign grant_d  = enable & d_req_valid & ~grant_if;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else if (!if_req_valid || grant_if) begin
      streak_q <= '0;
    end else if (grant_d && !streak_max) begin
      streak_q <= streak_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
//   clock, reset : clock and async active-low reset
//   bus          : fetch/data request-response handshakes and memory-side signals
// One transaction at a time: IDLE accepts, ACCESS holds mem_* for MEM_LATENCY cycles,
// RESP pulses the owner's response for one cycle.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY     = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  import mem_arb_pkg::*;

  localparam int unsigned LatW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t          state_q, state_d;
  owner_t          owner_q;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic            we_q, err_q;
  logic [1:0]      size_q;
  logic [LatW-1:0] lat_q;

  logic grant_if, grant_d, req_err, lat_last, in_access, in_resp;

  assign req_err   = req_misaligned(bus.d_size, bus.d_addr[1:0]);
  assign lat_last  = (lat_q == LatW'(MEM_LATENCY - 1));
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // Gating with reset keeps ready low while reset is held.
  mem_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clock       (clock),
    .reset       (reset),
    .enable      ((state_q == IDLE) && reset),
    .if_req_valid(bus.if_req_valid),
    .d_req_valid (bus.d_req_valid),
    .grant_if    (grant_if),
    .grant_d     (grant_d)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_if) begin
          state_d = ACCESS;
        end else if (grant_d) begin
          // Errored requests never touch memory.
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS:  if (lat_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_if) begin
        owner_q <= OWN_IF;
        addr_q  <= bus.if_addr;
        wdata_q <= '0;
        we_q    <= 1'b0;
        size_q  <= SIZE_WORD;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end else if (grant_d) begin
        owner_q <= OWN_D;
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        we_q    <= bus.d_we;
        size_q  <= bus.d_size;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (in_access) begin
        lat_q <= lat_last ? '0 : lat_q + 1'b1;
        if (lat_last) rdata_q <= we_q ? 32'd0 : bus.mem_data_out;
      end else begin
        lat_q <= '0;
      end
    end
  end

  assign bus.if_req_ready    = grant_if;
  assign bus.d_req_ready     = grant_d;

  assign bus.mem_address     = in_access ? addr_q  : 32'd0;
  assign bus.mem_data_in     = in_access ? wdata_q : 32'd0;
  assign bus.mem_read_write  = in_access & we_q;
  assign bus.mem_access_size = in_access ? size_q  : 2'b00;

  assign bus.if_rsp_valid    = in_resp && (owner_q == OWN_IF);
  assign bus.if_rsp_data     = bus.if_rsp_valid ? rdata_q : 32'd0;
  assign bus.d_rsp_valid     = in_resp && (owner_q == OWN_D);
  assign bus.d_rsp_data      = bus.d_rsp_valid ? rdata_q : 32'd0;
  assign bus.d_rsp_err       = bus.d_rsp_valid & err_q;

endmodule
